// File: rtl/fpu_result_io_bridge_pkg.sv
// Shared encodings for the FPU result export bridge: export modes, FSM states
// and the overflow counter width.
package fpu_io_pkg;
  localparam int OVF_W = 8;

  typedef enum logic [1:0] {
    MODE_PAR = 2'd0,
    MODE_SER = 2'd1,
    MODE_LA  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Encoding 3 is unassigned and falls back to parallel export.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_SER;
      2'd2:    return MODE_LA;
      default: return MODE_PAR;
    endcase
  endfunction
endpackage

// File: rtl/fpu_result_io_bridge_if.sv
// Result handshake between the FPU core (master) and the export bridge (slave).
interface fpu_result_io_bridge_if #(
  parameter int DATA_W = 32
);
  logic              res_valid_i;
  logic [DATA_W-1:0] res_data_i;
  logic              res_ready_o;

  modport master (output res_valid_i, output res_data_i, input res_ready_o);
  modport slave  (input res_valid_i, input res_data_i, output res_ready_o);
endinterface

// File: rtl/fpu_result_io_bridge_fifo.sv
// Small result FIFO with a combinational head view; push and pop may coincide
// at any occupancy, including a push into a full FIFO that is popped that cycle.
module fpu_result_fifo
  import fpu_io_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic [DATA_W-1:0] entries [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = entries[rd_ptr_reg];

  // Data storage is left unreset; occupancy alone says what is valid.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (do_push && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= push_data;
        end
      end
      assign entries[gi] = entry_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/fpu_result_io_bridge.sv
// Exports buffered FPU results as parallel pads, a framed serial stream or LA pops.
// Optional FPU_RESULT_PARITY_EN adds an even parity bit to every stored result.
module fpu_result_io_bridge
  import fpu_io_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PAD_W  = 32,
  parameter int SER_W  = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  fpu_result_io_bridge_if.slave res,
  input  logic [1:0]         mode_i,
  input  logic               la_pop_i,
  output logic [DATA_W-1:0]  la_data_o,
  output logic               la_valid_o,
  output logic [PAD_W-1:0]   pad_out_o,
  output logic               pad_oeb_o,
  output logic               pad_strobe_o,
  output logic               pad_frame_o,
  output logic [OVF_W-1:0]   ovf_cnt_o
);
`ifdef FPU_RESULT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENT_W      = DATA_W + PAR_W;
  localparam int DATA_BEATS = DATA_W / SER_W;
  localparam int NBEATS     = DATA_BEATS + PAR_W;
  localparam int BEAT_W     = $clog2(NBEATS) + 1;

  state_t             state_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [BEAT_W-1:0]  beat_reg;
  logic [PAD_W-1:0]   pad_reg;
  logic               strobe_reg;
  logic               frame_reg;
  logic               oeb_reg;
  logic               la_q_reg;
  logic [OVF_W-1:0]   ovf_reg;

  logic [ENT_W-1:0]   push_word;
  logic [ENT_W-1:0]   head_word;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               res_ready;
  logic               pop_now;
  logic               la_rise;
  logic               drop;
  mode_t              cur_mode;
  logic [PAD_W-1:0]   par_pad_next;
  logic [PAD_W-1:0]   head_chunk_next;
  logic [PAD_W-1:0]   shift_chunk_next;

`ifdef FPU_RESULT_PARITY_EN
  logic               par_reg;
  assign push_word = {^res.res_data_i, res.res_data_i};
`else
  assign push_word = res.res_data_i;
`endif
  assign head_data = head_word[DATA_W-1:0];

  fpu_result_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_l     (rst_l),
    .push      (res.res_valid_i && res_ready),
    .push_data (push_word),
    .pop       (pop_now),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_word)
  );

  // The mode input only matters while idle; a running frame always finishes.
  assign cur_mode = decode_mode(mode_i);
  assign la_rise  = la_pop_i && !la_q_reg;

  always_comb begin
    pop_now = 1'b0;
    if (rst_l && (state_reg == ST_IDLE) && !fifo_empty) begin
      pop_now = (cur_mode == MODE_LA) ? la_rise : 1'b1;
    end
  end

  assign res_ready       = rst_l && (!fifo_full || pop_now);
  assign res.res_ready_o = res_ready;
  assign drop            = res.res_valid_i && !res_ready;

  assign la_valid_o = rst_l && (state_reg == ST_IDLE) && (cur_mode == MODE_LA) && !fifo_empty;
  assign la_data_o  = la_valid_o ? head_data : '0;

  always_comb begin
    par_pad_next                = '0;
    par_pad_next[DATA_W-1:0]    = head_data;
    head_chunk_next             = '0;
    head_chunk_next[SER_W-1:0]  = head_data[DATA_W-1 -: SER_W];
    shift_chunk_next            = '0;
    shift_chunk_next[SER_W-1:0] = shift_reg[DATA_W-1 -: SER_W];
`ifdef FPU_RESULT_PARITY_EN
    if (PAD_W > DATA_W) par_pad_next[PAD_W-1] = head_word[DATA_W];
    if (beat_reg == BEAT_W'(DATA_BEATS - 1)) begin
      shift_chunk_next    = '0;
      shift_chunk_next[0] = par_reg;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_reg  <= ST_IDLE;
      shift_reg  <= '0;
      beat_reg   <= '0;
      pad_reg    <= '0;
      strobe_reg <= 1'b0;
      frame_reg  <= 1'b0;
      oeb_reg    <= 1'b1;
      la_q_reg   <= 1'b0;
      ovf_reg    <= '0;
`ifdef FPU_RESULT_PARITY_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      oeb_reg    <= 1'b0;
      la_q_reg   <= la_pop_i;
      strobe_reg <= 1'b0;
      frame_reg  <= 1'b0;
      if (drop && (ovf_reg != '1)) ovf_reg <= ovf_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (pop_now && (cur_mode == MODE_SER)) begin
            pad_reg    <= head_chunk_next;
            strobe_reg <= 1'b1;
            frame_reg  <= 1'b1;
            shift_reg  <= head_data << SER_W;
            beat_reg   <= '0;
            state_reg  <= ST_SHIFT;
`ifdef FPU_RESULT_PARITY_EN
            par_reg    <= head_word[DATA_W];
`endif
          end else if (pop_now && (cur_mode == MODE_PAR)) begin
            pad_reg    <= par_pad_next;
            strobe_reg <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (beat_reg == BEAT_W'(NBEATS - 1)) begin
            pad_reg   <= '0;
            state_reg <= ST_GAP;
          end else begin
            pad_reg    <= shift_chunk_next;
            strobe_reg <= 1'b1;
            shift_reg  <= shift_reg << SER_W;
            beat_reg   <= beat_reg + 1'b1;
          end
        end
        ST_GAP:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign pad_out_o    = pad_reg;
  assign pad_oeb_o    = oeb_reg;
  assign pad_strobe_o = strobe_reg;
  assign pad_frame_o  = frame_reg;
  assign ovf_cnt_o    = ovf_reg;
endmodule

// File: tb/tb_fpu_result_io_bridge.sv
// Directed bench for fpu_result_io_bridge in its default (no parity) build.
module tb_fpu_result_io_bridge;
  logic        clk = 1'b0;
  logic        rst_l;
  logic [1:0]  mode;
  logic        la_pop;
  logic [31:0] la_data;
  logic        la_valid;
  logic [31:0] pad_out;
  logic        pad_oeb;
  logic        pad_strobe;
  logic        pad_frame;
  logic [7:0]  ovf_cnt;

  int vectors = 0;
  int miscompares = 0;

  fpu_result_io_bridge_if #(.DATA_W(32)) res_bus ();

  fpu_result_io_bridge #(
    .DATA_W (32), .DEPTH (4), .PAD_W (32), .SER_W (4)
  ) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .res          (res_bus),
    .mode_i       (mode),
    .la_pop_i     (la_pop),
    .la_data_o    (la_data),
    .la_valid_o   (la_valid),
    .pad_out_o    (pad_out),
    .pad_oeb_o    (pad_oeb),
    .pad_strobe_o (pad_strobe),
    .pad_frame_o  (pad_frame),
    .ovf_cnt_o    (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_l = 1'b0; mode = 2'd0; la_pop = 1'b0;
    res_bus.res_valid_i = 1'b1; res_bus.res_data_i = 32'hDEADBEEF;
    repeat (3) tick();
    vectors++;
    if (pad_out !== 32'h0 || pad_strobe !== 1'b0 || pad_frame !== 1'b0 || la_valid !== 1'b0
        || la_data !== 32'h0 || res_bus.res_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: pad=%h strb=%b frm=%b lav=%b lad=%h rdy=%b required all 0",
               pad_out, pad_strobe, pad_frame, la_valid, la_data, res_bus.res_ready_o);
    end
    vectors++;
    if (pad_oeb !== 1'b1 || ovf_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_oeb_ovf: oeb=%b ovf=%0d required oeb=1 ovf=0", pad_oeb, ovf_cnt);
    end
    res_bus.res_valid_i = 1'b0; rst_l = 1'b1; mode = 2'd2;
    tick();
    vectors++;
    if (la_valid !== 1'b0 || pad_oeb !== 1'b0 || res_bus.res_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_push: la_valid=%b oeb=%b rdy=%b required 0,0,1", la_valid, pad_oeb, res_bus.res_ready_o);
    end
    $display("reset: done, vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic push_one(input logic [31:0] d);
    res_bus.res_valid_i = 1'b1; res_bus.res_data_i = d;
    tick();
    res_bus.res_valid_i = 1'b0;
  endtask

  task automatic test_parallel(input logic [1:0] m, input logic [31:0] d);
    mode = m;
    push_one(d);
    vectors++;
    if (pad_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL par_n1_strobe: strobe=%b required 0", pad_strobe);
    end
    tick();
    vectors++;
    if (pad_out !== d || pad_strobe !== 1'b1 || pad_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL par_n2: pad=%h strb=%b frm=%b required %h,1,0", pad_out, pad_strobe, pad_frame, d);
    end
    tick();
    vectors++;
    if (pad_out !== d || pad_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL par_hold: pad=%h strb=%b required %h,0", pad_out, pad_strobe, d);
    end
    $display("parallel mode=%0d data=%h: pad=%h", m, d, pad_out);
  endtask

  task automatic test_serial();
    logic [3:0] exp_nib [8] = '{4'hC, 4'h0, 4'h4, 4'h9, 4'h0, 4'hF, 4'hD, 4'hB};
    mode = 2'd1;
    push_one(32'hC0490FDB);
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (pad_out !== {28'h0, exp_nib[i]} || pad_strobe !== 1'b1 || pad_frame !== (i == 0)) begin
        miscompares++;
        $display("FAIL ser_beat%0d: pad=%h strb=%b frm=%b required %h,1,%b", i, pad_out, pad_strobe,
                 pad_frame, exp_nib[i], (i == 0));
      end
      tick();
    end
    vectors++;
    if (pad_out !== 32'h0 || pad_strobe !== 1'b0 || pad_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL ser_gap: pad=%h strb=%b frm=%b required 0,0,0", pad_out, pad_strobe, pad_frame);
    end
    tick();
    vectors++;
    if (pad_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL ser_idle: strobe=%b required 0", pad_strobe);
    end
    $display("serial C0490FDB: 8 beats and gap checked");
  endtask

  task automatic test_mode_change();
    logic [3:0] exp_nib [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    mode = 2'd1;
    push_one(32'h12345678);
    tick();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (pad_out !== {28'h0, exp_nib[i]} || pad_strobe !== 1'b1 || pad_frame !== (i == 0)) begin
        miscompares++;
        $display("FAIL chg_beat%0d: pad=%h strb=%b frm=%b required %h,1,%b", i, pad_out, pad_strobe,
                 pad_frame, exp_nib[i], (i == 0));
      end
      if (i == 1) begin
        res_bus.res_valid_i = 1'b1; res_bus.res_data_i = 32'hA5A50F0F;
      end
      if (i == 2) res_bus.res_valid_i = 1'b0;
      if (i == 3) mode = 2'd0;
      tick();
    end
    vectors++;
    if (pad_out !== 32'h0 || pad_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_gap: pad=%h strb=%b required 0,0", pad_out, pad_strobe);
    end
    tick();
    vectors++;
    if (pad_out !== 32'h0 || pad_strobe !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_idle: pad=%h strb=%b required 0,0", pad_out, pad_strobe);
    end
    tick();
    vectors++;
    if (pad_out !== 32'hA5A50F0F || pad_strobe !== 1'b1 || pad_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL chg_par: pad=%h strb=%b frm=%b required a5a50f0f,1,0", pad_out, pad_strobe, pad_frame);
    end
    tick();
    $display("mode change mid-frame: frame completed, then parallel pad=%h", pad_out);
  endtask

  task automatic la_edge();
    la_pop = 1'b1;
    tick();
    la_pop = 1'b0;
    tick();
  endtask

  task automatic test_la_pop();
    logic [31:0] d [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    logic [31:0] pad_before;
    mode = 2'd2;
    pad_before = pad_out;
    for (int k = 0; k < 5; k++) begin
      res_bus.res_valid_i = 1'b1; res_bus.res_data_i = d[k];
      tick();
    end
    res_bus.res_valid_i = 1'b0;
    vectors++;
    if (ovf_cnt !== 8'd1 || res_bus.res_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL la_ovf: ovf=%0d rdy=%b required 1,0", ovf_cnt, res_bus.res_ready_o);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (la_valid !== 1'b1 || la_data !== d[k]) begin
        miscompares++;
        $display("FAIL la_pop%0d: valid=%b data=%h required 1,%h", k, la_valid, la_data, d[k]);
      end
      la_edge();
    end
    vectors++;
    if (la_valid !== 1'b0 || la_data !== 32'h0 || pad_out !== pad_before) begin
      miscompares++;
      $display("FAIL la_empty: valid=%b data=%h pad=%h required 0,0,%h", la_valid, la_data, pad_out, pad_before);
    end
    la_edge();
    vectors++;
    if (la_valid !== 1'b0 || ovf_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL la_edge_empty: valid=%b ovf=%0d required 0,1", la_valid, ovf_cnt);
    end
    $display("la pop: 5 pushed, 4 popped in order, ovf=%0d", ovf_cnt);
  endtask

  task automatic test_full_simul();
    logic [31:0] d [5] = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hB0000005};
    mode = 2'd2;
    for (int k = 0; k < 4; k++) begin
      res_bus.res_valid_i = 1'b1; res_bus.res_data_i = d[k];
      tick();
    end
    res_bus.res_valid_i = 1'b0;
    vectors++;
    if (res_bus.res_ready_o !== 1'b0 || ovf_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL full_state: rdy=%b ovf=%0d required 0,1", res_bus.res_ready_o, ovf_cnt);
    end
    res_bus.res_valid_i = 1'b1; res_bus.res_data_i = d[4]; la_pop = 1'b1;
    #1;
    vectors++;
    if (res_bus.res_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL full_simul_ready: rdy=%b required 1", res_bus.res_ready_o);
    end
    tick();
    res_bus.res_valid_i = 1'b0; la_pop = 1'b0;
    vectors++;
    if (ovf_cnt !== 8'd1 || res_bus.res_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_simul_after: ovf=%0d rdy=%b required 1,0", ovf_cnt, res_bus.res_ready_o);
    end
    tick();
    for (int k = 1; k < 5; k++) begin
      vectors++;
      if (la_valid !== 1'b1 || la_data !== d[k]) begin
        miscompares++;
        $display("FAIL full_drain%0d: valid=%b data=%h required 1,%h", k, la_valid, la_data, d[k]);
      end
      la_edge();
    end
    vectors++;
    if (la_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain_empty: valid=%b required 0", la_valid);
    end
    $display("full FIFO simultaneous push/pop: occupancy held at 4, ovf=%0d", ovf_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_parallel(2'd0, 32'h3F800000);
    test_serial();
    test_mode_change();
    test_parallel(2'd3, 32'h0BADF00D);
    test_la_pop();
    test_full_simul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
